// File: rtl/mem_wb_stage.sv
// Memory-access and writeback stage: issues load/store requests over a req/ack bus,
// formats load data and drives the register-file write port.
module mem_wb_stage #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    // Upstream handshake: an instruction transfers on a rising edge where in_valid & in_ready.
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       opcode,
    input  logic [2:0]       func3,
    input  logic [4:0]       rd_in,
    input  logic [WIDTH-1:0] alu_result,
    input  logic [WIDTH-1:0] store_data,
    input  logic [WIDTH-1:0] pc_plus4,
    input  logic [WIDTH-1:0] csr_rdata,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic [WIDTH-1:0] dmem_addr,
    output logic [WIDTH-1:0] dmem_wdata,
    output logic [3:0]       dmem_wmask,
    input  logic             dmem_ack,
    input  logic [WIDTH-1:0] dmem_rdata,
    output logic             reg_wr,
    output logic [4:0]       rd_m2w,
    output logic [WIDTH-1:0] wbdata,
    output logic             misalign,
    output logic             bus_err,
    output logic             state_dbg
);

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_CSR   = 7'b1110011;
    localparam int         CW       = $clog2(TIMEOUT + 1);

    typedef enum logic {RUN = 1'b0, MEM = 1'b1} state_e;

    state_e          state;
    logic [CW-1:0]   tmo_cnt;
    logic            lat_load;
    logic [2:0]      lat_func3;
    logic [1:0]      lat_off;
    logic [4:0]      lat_rd;

    logic             is_mem;
    logic             misaligned;
    logic             alu_wr;
    logic [WIDTH-1:0] alu_wdata;
    logic [3:0]       st_mask;
    logic [WIDTH-1:0] st_wdata;
    logic             ld_ok;
    logic [WIDTH-1:0] ld_data;
    logic [WIDTH-1:0] byte_lane;
    logic [WIDTH-1:0] half_lane;

    assign state_dbg = state;
    assign is_mem    = (opcode == OP_LOAD) || (opcode == OP_STORE);
    assign misaligned = ((func3[1:0] == 2'b01) && alu_result[0]) ||
                        ((func3[1:0] == 2'b10) && (alu_result[1:0] != 2'b00));

    always_comb begin
        alu_wr    = 1'b1;
        alu_wdata = alu_result;
        case (opcode)
            OP_R, OP_I, OP_LUI, OP_AUIPC: alu_wdata = alu_result;
            OP_JAL, OP_JALR:              alu_wdata = pc_plus4;
            OP_CSR:                       alu_wdata = csr_rdata;
            default:                      alu_wr    = 1'b0;
        endcase
    end

    always_comb begin
        st_mask  = 4'b1111;
        st_wdata = store_data;
        case (func3[1:0])
            2'b00: begin
                st_mask  = 4'b0001 << alu_result[1:0];
                st_wdata = {(WIDTH/8){store_data[7:0]}};
            end
            2'b01: begin
                st_mask  = 4'b0011 << alu_result[1:0];
                st_wdata = {(WIDTH/16){store_data[15:0]}};
            end
            default: ;
        endcase
    end

    // Lane selection uses the byte offset captured at issue, not the aligned bus address.
    assign byte_lane = dmem_rdata >> {lat_off, 3'b000};
    assign half_lane = dmem_rdata >> {lat_off[1], 4'b0000};

    always_comb begin
        ld_ok   = 1'b1;
        ld_data = '0;
        case (lat_func3)
            3'b000:  ld_data = {{(WIDTH-8){byte_lane[7]}}, byte_lane[7:0]};
            3'b001:  ld_data = {{(WIDTH-16){half_lane[15]}}, half_lane[15:0]};
            3'b010:  ld_data = dmem_rdata;
            3'b100:  ld_data = {{(WIDTH-8){1'b0}}, byte_lane[7:0]};
            3'b101:  ld_data = {{(WIDTH-16){1'b0}}, half_lane[15:0]};
            default: ld_ok   = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RUN;
            in_ready   <= 1'b1;
            tmo_cnt    <= '0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            dmem_wmask <= '0;
            reg_wr     <= 1'b0;
            rd_m2w     <= '0;
            wbdata     <= '0;
            misalign   <= 1'b0;
            bus_err    <= 1'b0;
            lat_load   <= 1'b0;
            lat_func3  <= '0;
            lat_off    <= '0;
            lat_rd     <= '0;
        end else begin
            reg_wr   <= 1'b0;
            misalign <= 1'b0;
            bus_err  <= 1'b0;
            case (state)
                RUN: begin
                    if (in_valid && is_mem) begin
                        if (misaligned) begin
                            misalign <= 1'b1;
                        end else begin
                            state      <= MEM;
                            in_ready   <= 1'b0;
                            tmo_cnt    <= '0;
                            dmem_req   <= 1'b1;
                            dmem_we    <= (opcode == OP_STORE);
                            dmem_addr  <= {alu_result[WIDTH-1:2], 2'b00};
                            dmem_wdata <= (opcode == OP_STORE) ? st_wdata : '0;
                            dmem_wmask <= (opcode == OP_STORE) ? st_mask : 4'b1111;
                            lat_load   <= (opcode == OP_LOAD);
                            lat_func3  <= func3;
                            lat_off    <= alu_result[1:0];
                            lat_rd     <= rd_in;
                        end
                    end else if (in_valid && alu_wr && (rd_in != 5'd0)) begin
                        reg_wr <= 1'b1;
                        rd_m2w <= rd_in;
                        wbdata <= alu_wdata;
                    end
                end
                MEM: begin
                    if (dmem_ack) begin
                        state    <= RUN;
                        in_ready <= 1'b1;
                        dmem_req <= 1'b0;
                        if (lat_load) begin
                            reg_wr <= ld_ok && (lat_rd != 5'd0);
                            rd_m2w <= lat_rd;
                            wbdata <= ld_data;
                        end
                    end else if (tmo_cnt == CW'(TIMEOUT - 1)) begin
                        state    <= RUN;
                        in_ready <= 1'b1;
                        dmem_req <= 1'b0;
                        bus_err  <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: directed cases plus random instructions checked against a
// transaction-level model of the writeback and memory-bus rules.
module tb_mem_wb_stage;

    localparam int TIMEOUT = 16;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_CSR   = 7'b1110011;
    localparam logic [6:0] OP_BAD   = 7'b1111111;

    logic        clk, rst_n;
    logic        in_valid, in_ready;
    logic [6:0]  opcode;
    logic [2:0]  func3;
    logic [4:0]  rd_in;
    logic [31:0] alu_result, store_data, pc_plus4, csr_rdata;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_wmask;
    logic        reg_wr;
    logic [4:0]  rd_m2w;
    logic [31:0] wbdata;
    logic        misalign, bus_err, state_dbg;

    int n_checks = 0;
    int n_pass   = 0;

    mem_wb_stage #(.WIDTH(32), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .func3(func3), .rd_in(rd_in), .alu_result(alu_result),
        .store_data(store_data), .pc_plus4(pc_plus4), .csr_rdata(csr_rdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_wmask(dmem_wmask), .dmem_ack(dmem_ack),
        .dmem_rdata(dmem_rdata), .reg_wr(reg_wr), .rd_m2w(rd_m2w), .wbdata(wbdata),
        .misalign(misalign), .bus_err(bus_err), .state_dbg(state_dbg)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    endtask

    // Reference: what a non-memory instruction writes back, if anything.
    function automatic void model_alu(input logic [6:0] op, input logic [31:0] alu,
                                      input logic [31:0] pc4, input logic [31:0] csr,
                                      output bit wr, output logic [31:0] data);
        wr = 1'b1;
        data = alu;
        if (op == OP_JAL || op == OP_JALR) data = pc4;
        else if (op == OP_CSR) data = csr;
        else if (!(op == OP_R || op == OP_I || op == OP_LUI || op == OP_AUIPC)) wr = 1'b0;
    endfunction

    function automatic void model_load(input logic [2:0] f3, input int off,
                                       input logic [31:0] rdata,
                                       output bit ok, output logic [31:0] data);
        logic [31:0] b, h;
        b = (rdata >> (8 * off)) & 32'hFF;
        h = (rdata >> (16 * (off / 2))) & 32'hFFFF;
        ok = 1'b1;
        data = 32'h0;
        case (f3)
            3'd0: data = (b >= 128) ? b - 32'd256 : b;
            3'd1: data = (h >= 32768) ? h - 32'd65536 : h;
            3'd2: data = rdata;
            3'd4: data = b;
            3'd5: data = h;
            default: ok = 1'b0;
        endcase
    endfunction

    function automatic bit model_misaligned(input logic [2:0] f3, input logic [31:0] a);
        int sz;
        sz = int'(f3) % 4;
        return (sz == 1 && (a % 2) != 0) || (sz == 2 && (a % 4) != 0);
    endfunction

    // Starts and ends just after a falling edge. ack_dly < 0 means the bus never answers.
    task automatic do_instr(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd,
                            input logic [31:0] alu, input logic [31:0] sd,
                            input logic [31:0] pc4, input logic [31:0] csr,
                            input int ack_dly, input logic [31:0] rdata);
        bit          wr_exp, ok;
        logic [31:0] d_exp, mask_exp, wd_exp;
        int          off;
        off = int'(alu % 4);
        check("in_ready_before", in_ready, 1);
        in_valid = 1'b1; opcode = op; func3 = f3; rd_in = rd;
        alu_result = alu; store_data = sd; pc_plus4 = pc4; csr_rdata = csr;
        @(negedge clk);
        in_valid = 1'b0;
        if (!(op == OP_LOAD || op == OP_STORE)) begin
            model_alu(op, alu, pc4, csr, wr_exp, d_exp);
            wr_exp = wr_exp && (rd != 0);
            check("alu_reg_wr", reg_wr, wr_exp);
            if (wr_exp) begin
                check("alu_rd", rd_m2w, rd);
                check("alu_wbdata", wbdata, d_exp);
            end
            check("alu_no_req", dmem_req, 0);
        end else if (model_misaligned(f3, alu)) begin
            check("mis_pulse", misalign, 1);
            check("mis_no_req", dmem_req, 0);
            check("mis_reg_wr", reg_wr, 0);
        end else begin
            check("mem_req", dmem_req, 1);
            check("mem_we", dmem_we, op == OP_STORE);
            check("mem_addr", dmem_addr, alu - off);
            check("mem_in_ready", in_ready, 0);
            check("mem_reg_wr", reg_wr, 0);
            if (op == OP_STORE) begin
                mask_exp = (f3 == 0) ? (32'd1 << off) : (f3 == 1) ? (32'd3 << off) : 32'd15;
                wd_exp = (f3 == 0) ? (sd & 32'hFF) * 32'h01010101 :
                         (f3 == 1) ? (sd & 32'hFFFF) * 32'h00010001 : sd;
                check("st_mask", dmem_wmask, mask_exp);
                check("st_wdata", dmem_wdata, wd_exp);
            end else begin
                check("ld_mask", dmem_wmask, 15);
            end
            if (ack_dly < 0) begin
                for (int k = 1; k < TIMEOUT; k++) begin
                    @(negedge clk);
                    check("tmo_req_held", dmem_req, 1);
                end
                @(negedge clk);
                check("tmo_req_drop", dmem_req, 0);
                check("tmo_bus_err", bus_err, 1);
                check("tmo_reg_wr", reg_wr, 0);
                check("tmo_in_ready", in_ready, 1);
            end else begin
                for (int k = 0; k < ack_dly; k++) begin
                    // Upstream keeps offering junk while the stage is busy.
                    in_valid = 1'($urandom_range(0, 1));
                    opcode = OP_R; rd_in = 5'd7; alu_result = $urandom;
                    @(negedge clk);
                    check("wait_req", dmem_req, 1);
                    check("wait_in_ready", in_ready, 0);
                    check("wait_addr", dmem_addr, alu - off);
                    check("wait_reg_wr", reg_wr, 0);
                end
                in_valid = 1'b0;
                dmem_ack = 1'b1;
                dmem_rdata = rdata;
                @(negedge clk);
                dmem_ack = 1'b0;
                dmem_rdata = $urandom;
                check("ack_req_drop", dmem_req, 0);
                check("ack_in_ready", in_ready, 1);
                if (op == OP_LOAD) begin
                    model_load(f3, off, rdata, ok, d_exp);
                    wr_exp = ok && (rd != 0);
                    check("ld_reg_wr", reg_wr, wr_exp);
                    if (wr_exp) begin
                        check("ld_rd", rd_m2w, rd);
                        check("ld_wbdata", wbdata, d_exp);
                    end
                end else begin
                    check("st_reg_wr", reg_wr, 0);
                end
            end
        end
    endtask

    // Idle cycle; a stray ack while running must have no effect.
    task automatic idle(input bit spur_ack);
        in_valid = 1'b0;
        dmem_ack = spur_ack;
        dmem_rdata = $urandom;
        @(negedge clk);
        dmem_ack = 1'b0;
        check("idle_reg_wr", reg_wr, 0);
        check("idle_req", dmem_req, 0);
        check("idle_misalign", misalign, 0);
        check("idle_bus_err", bus_err, 0);
    endtask

    logic [6:0] op_tab [10];
    logic [6:0] r_op;
    logic [2:0] r_f3;
    logic [4:0] r_rd;
    logic [31:0] r_alu;
    int r_sel, r_dly;

    initial begin
        op_tab = '{OP_R, OP_I, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_CSR, OP_BR, OP_BAD, OP_LOAD};
        rst_n = 1'b0; in_valid = 1'b0; opcode = '0; func3 = '0; rd_in = '0;
        alu_result = '0; store_data = '0; pc_plus4 = '0; csr_rdata = '0;
        dmem_ack = 1'b0; dmem_rdata = '0;
        #23;
        check("rst_in_ready", in_ready, 1);
        check("rst_req", dmem_req, 0);
        check("rst_we", dmem_we, 0);
        check("rst_addr", dmem_addr, 0);
        check("rst_wdata", dmem_wdata, 0);
        check("rst_wmask", dmem_wmask, 0);
        check("rst_reg_wr", reg_wr, 0);
        check("rst_rd", rd_m2w, 0);
        check("rst_wbdata", wbdata, 0);
        check("rst_misalign", misalign, 0);
        check("rst_bus_err", bus_err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases
        do_instr(OP_R, 3'd0, 5'd5, 32'h0000_1234, 0, 0, 0, 0, 0);
        do_instr(OP_R, 3'd0, 5'd0, 32'h0000_1234, 0, 0, 0, 0, 0);
        idle(1'b0);
        do_instr(OP_LOAD, 3'd0, 5'd9, 32'h0000_0103, 0, 0, 0, 3, 32'h80FF_FF7F);
        idle(1'b0);
        do_instr(OP_LOAD, 3'd4, 5'd9, 32'h0000_0103, 0, 0, 0, 3, 32'h80FF_FF7F);
        idle(1'b0);
        do_instr(OP_STORE, 3'd1, 5'd0, 32'h0000_0202, 32'h0000_ABCD, 0, 0, 2, 0);
        idle(1'b0);
        do_instr(OP_LOAD, 3'd2, 5'd3, 32'h0000_0201, 0, 0, 0, 0, 0);
        do_instr(OP_JAL, 3'd0, 5'd1, 32'hDEAD_0000, 0, 32'h0000_0044, 0, 0, 0);
        do_instr(OP_CSR, 3'd2, 5'd2, 0, 0, 0, 32'hCAFE_F00D, 0, 0);
        idle(1'b1);
        do_instr(OP_LOAD, 3'd2, 5'd4, 32'h0000_0400, 0, 0, 0, -1, 0);
        idle(1'b0);

        // Random instruction stream
        for (int n = 0; n < 300; n++) begin
            r_sel = $urandom_range(0, 13);
            r_op = (r_sel < 10) ? op_tab[r_sel] : (r_sel < 12) ? OP_LOAD : OP_STORE;
            if (r_sel == 9) r_op = OP_STORE;
            r_f3 = (r_op == OP_STORE) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
            r_rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            r_alu = $urandom;
            if ($urandom_range(0, 1) == 1) r_alu = r_alu & 32'hFFFF_FFFC;
            r_dly = ($urandom_range(0, 19) == 0) ? -1 : $urandom_range(0, TIMEOUT - 1);
            do_instr(r_op, r_f3, r_rd, r_alu, $urandom, $urandom, $urandom, r_dly, $urandom);
            if ($urandom_range(0, 2) == 0) idle(1'($urandom_range(0, 1)));
        end
        idle(1'b0);

        // Asynchronous reset in the middle of an outstanding load
        in_valid = 1'b1; opcode = OP_LOAD; func3 = 3'd2; rd_in = 5'd6; alu_result = 32'h300;
        @(negedge clk);
        in_valid = 1'b0;
        check("rmid_req_up", dmem_req, 1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rmid_req_drop", dmem_req, 0);
        check("rmid_reg_wr", reg_wr, 0);
        check("rmid_in_ready", in_ready, 1);
        dmem_ack = 1'b1;
        dmem_rdata = 32'h1111_2222;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        dmem_ack = 1'b0;
        check("rrel_reg_wr", reg_wr, 0);
        check("rrel_req", dmem_req, 0);
        check("rrel_in_ready", in_ready, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Global guard against a stalled run.
    initial begin
        #2000000;
        $display("FAIL global_timeout got=%0d exp=%0d", n_checks, n_checks + 1);
        $fatal(1, "bench timed out");
    end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Memory-access and writeback stage of the 3-stage RISC-V pipeline.
- Accepts one executed instruction per handshake and performs the data-memory access for loads and stores over a req/ack bus.
- Formats the load data and produces the register-file write port (reg_wr, rd_m2w, wbdata) that the decode stage consumes on the falling clock edge.
- Stalls upstream while a memory access is outstanding.

Parameters:
- WIDTH, 32, datapath and address width.
- TIMEOUT, 16, cycles to wait for dmem_ack before aborting with bus_err.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  execute stage presents an instruction.
- in_ready  out  1  stage can accept; transfer occurs when in_valid & in_ready.
- opcode  in  7  opcode_type_e value of the instruction.
- func3  in  3  instruction func3.
- rd_in  in  5  destination register.
- alu_result  in  WIDTH  ALU result; also the memory address for loads and stores.
- store_data  in  WIDTH  rs2 value for stores.
- pc_plus4  in  WIDTH  link value for JAL/JALR.
- csr_rdata  in  WIDTH  CSR read value.
- dmem_req  out  1  memory request.
- dmem_we  out  1  1 = store.
- dmem_addr  out  WIDTH  word-aligned address ({alu_result[31:2],2'b00}).
- dmem_wdata  out  WIDTH  store data, lane-replicated.
- dmem_wmask  out  4  byte enables.
- dmem_ack  in  1  completes the request.
- dmem_rdata  in  WIDTH  read word, valid with dmem_ack.
- reg_wr  out  1  register-file write enable.
- rd_m2w  out  5  write address.
- wbdata  out  WIDTH  write data.
- misalign  out  1  one-cycle pulse on a misaligned access.
- bus_err  out  1  one-cycle pulse on a memory timeout.

Behaviour:
- Reset: state=RUN, in_ready=1. The following are all 0: dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wmask, reg_wr, rd_m2w, wbdata, misalign, bus_err. Timeout counter=0.
- Reset is asynchronous: asserting rst_n mid-access drops dmem_req immediately, and any pending write is discarded.
- FSM states:
  - RUN: in_ready=1.
  - MEM: in_ready=0; request outstanding.
- RUN, accepted non-memory instruction: next edge registers reg_wr, rd_m2w and wbdata (1-cycle latency). Write data by opcode:
  - R_TYPE, I_TYPE, LUI, AUIPC -> alu_result.
  - JAL, JALR -> pc_plus4.
  - CSR -> csr_rdata.
  - S_TYPE, B_TYPE, illegal/other -> reg_wr=0.
- reg_wr is forced 0 whenever rd_in==0.
- reg_wr is a single-cycle pulse unless a new write follows back-to-back; rd_m2w and wbdata hold their last values.
- RUN, accepted L_TYPE or S_TYPE, aligned: next edge sets dmem_req=1 with address, we, wdata and mask; state goes to MEM; reg_wr=0.
- Alignment rules:
  - Half-word (func3[1:0]=01) requires addr[0]=0.
  - Word (10) requires addr[1:0]=00.
- Misaligned access: no request is issued, misalign pulses 1 cycle, reg_wr=0, state stays RUN.
- Store lanes by func3:
  - SB: wmask = 0001 << addr[1:0]; wdata = byte replicated x4.
  - SH: wmask = 0011 << addr[1:0]; wdata = half replicated x2.
  - SW: wmask = 1111.
- Loads: dmem_we=0, wmask=1111.
- MEM: all dmem_* outputs are held stable until dmem_ack. in_valid is ignored.
- On dmem_ack (sampled at a rising edge):
  - dmem_req drops on that edge and state returns to RUN.
  - For a load, that same edge registers reg_wr=1 (if rd!=0), rd_m2w and the formatted wbdata.
  - For a store, reg_wr=0.
  - in_ready returns to 1 in the cycle after the ack edge.
- Load format (lane selected by addr[1:0]):
  - LB: sign-extend byte.
  - LH: sign-extend half.
  - LW: full word.
  - LBU: zero-extend byte.
  - LHU: zero-extend half.
  - Other func3 -> wbdata=0, reg_wr=0.
- Timeout: the counter increments each MEM cycle without ack.
  - When it reaches TIMEOUT, dmem_req drops, bus_err pulses 1 cycle, reg_wr=0, state returns to RUN.
  - The counter clears on entry to MEM.
- dmem_ack while in RUN is ignored.

Test Plan:
- ADD result: opcode R_TYPE, rd=5, alu_result=0x0000_1234 -> one cycle later reg_wr=1, rd_m2w=5, wbdata=0x0000_1234. The same instruction with rd=0 -> reg_wr=0.
- LB sign extension: addr=0x103, dmem_rdata=0x80FF_FF7F, ack after 3 cycles -> dmem_addr=0x100; wbdata=0xFFFF_FF80. The same access as LBU -> wbdata=0x0000_0080. in_ready=0 throughout the wait.
- SH: addr=0x202, store_data=0x0000_ABCD -> dmem_we=1, wmask=1100, wdata=0xABCD_ABCD; after ack, reg_wr=0 and in_ready=1.
- Misaligned: LW at addr=0x201 -> misalign pulses once, dmem_req stays 0, reg_wr=0. The next instruction is accepted the following cycle.
- Timeout: load with no ack, TIMEOUT=16 -> dmem_req is high for 16 cycles, then bus_err pulses once and the stage returns to RUN.
- Reset mid-access: assert rst_n low during MEM -> dmem_req=0 immediately, no reg_wr. After release, in_ready=1.
